mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DEPTH_WORDS, 256, number of 32-bit words in data memory (power of two).
REQ-002 Parameter: ADDR_W, log2(DEPTH_WORDS), word-index width, derived and not overridden.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 zero_out, ALU_out, pc_out, reg2_data_out, rd_out, func3_out  in  1/32/32/32/5/3  EX/MEM register contents: zero flag, ALU result/address, branch target, store data, dest reg, funct3.
REQ-006 MemtoReg_WB_out, RegWrite_WB_out, MemRead_MEM_out, MemWrite_MEM_out, Branch_MEM_out  in  1 each  EX/MEM control bits.
REQ-007 PCSrc  out  1  combinational branch-taken to fetch.
REQ-008 branch_target  out  32  combinational, equals pc_out.
REQ-009 mem_data_wb, alu_wb  out  32 each  registered load data and ALU result for WB.
REQ-010 rd_wb, MemtoReg_wb, RegWrite_wb, misaligned_wb  out  5/1/1/1  registered WB controls and misalignment flag.

Function
REQ-011 PCSrc SHALL be Branch_MEM_out & ((func3=000 & zero) | (func3=001 & !zero)); other func3 values SHALL give 0.
REQ-012 Word index SHALL be ALU_out[ADDR_W+1:2]; higher address bits ignored (wrap-around modulo memory size).
REQ-013 Memory read SHALL be combinational; MEM/WB outputs SHALL update at the next rising edge (1-cycle latency).
REQ-014 Loads by func3: 000 LB, 001 LH sign-extended; 100 LBU, 101 LHU zero-extended; 010 LW; lane chosen by ALU_out[1:0].
REQ-015 Stores by func3: 000 SB, 001 SH, 010 SW using low bits of reg2_data_out, per-byte write enables; unaddressed bytes unchanged.
REQ-016 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL suppress the store, force mem_data_wb=0 and set misaligned_wb=1 for one cycle.
REQ-017 Undefined func3 with MemRead/MemWrite SHALL act as misaligned (no write, data 0, flag set).
REQ-018 Write SHALL commit on the rising edge when MemWrite_MEM_out=1 and reset=0.
REQ-019 Simultaneous MemRead and MemWrite SHALL perform the write; mem_data_wb returns pre-write contents.
REQ-020 MemRead=0 SHALL register mem_data_wb=0.
REQ-021 alu_wb, rd_wb, MemtoReg_wb, RegWrite_wb SHALL register ALU_out, rd_out, MemtoReg_WB_out, RegWrite_WB_out unchanged.
REQ-022 RegWrite_wb SHALL be forced 0 when a misaligned load occurs.

Reset
REQ-023 With reset=1 at a rising edge, every registered output SHALL become 0.
REQ-024 Memory contents SHALL NOT be reset; a store presented in a reset cycle SHALL be dropped.
REQ-025 PCSrc SHALL be 0 whenever Branch_MEM_out=0, independent of reset.

Structure
REQ-026 Shared package SHALL hold funct3 load/store/branch encodings and the 32-bit data width constant.
REQ-027 Memory array with byte enables SHALL be a sub-module named data_mem; lane select, extension and MEM/WB register stay in mem_stage.

Verification
REQ-028 SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> mem_data_wb=0xDEADBEEF one cycle after load.
REQ-029 SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; bytes 0x10-0x12 unchanged.
REQ-030 SH to 0x11 -> no write, misaligned_wb=1, RegWrite_wb=0 on a load to 0x11.
REQ-031 Branch=1, func3=000, zero=1, pc_out=0x40 -> PCSrc=1, branch_target=0x40; func3=001 same zero -> PCSrc=0.
REQ-032 Store issued with reset=1 -> later load of that address returns prior contents; all WB outputs 0 after reset edge.
REQ-033 SW to addr DEPTH_WORDS*4+8 -> LW 0x8 returns stored value (wrap-around).

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: funct3 encodings, data width and the MEM/WB register layout shared by the memory stage.
package mem_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  typedef struct packed {
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] alu;
    logic [4:0]      rd;
    logic            mtr;
    logic            rw;
    logic            mis;
  } wb_t;
  function automatic logic is_load(input logic [2:0] f);
    return f inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction
  function automatic logic is_store(input logic [2:0] f);
    return f inside {F3_SB, F3_SH, F3_SW};
  endfunction
endpackage

// File: rtl/data_mem.sv
// data_mem: word-organised data memory with per-byte write enables and combinational read; contents are never reset.
module data_mem import mem_stage_pkg::*; #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);
  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  assign rdata_o = mem_q[addr_i];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: branch resolution, load/store lane handling with misalignment trapping, and the MEM/WB register.
module mem_stage import mem_stage_pkg::*; #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            zero_out,
  input  logic [XLEN-1:0] ALU_out,
  input  logic [XLEN-1:0] pc_out,
  input  logic [XLEN-1:0] reg2_data_out,
  input  logic [4:0]      rd_out,
  input  logic [2:0]      func3_out,
  input  logic            MemtoReg_WB_out,
  input  logic            RegWrite_WB_out,
  input  logic            MemRead_MEM_out,
  input  logic            MemWrite_MEM_out,
  input  logic            Branch_MEM_out,
  output logic            PCSrc,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] mem_data_wb,
  output logic [XLEN-1:0] alu_wb,
  output logic [4:0]      rd_wb,
  output logic            MemtoReg_wb,
  output logic            RegWrite_wb,
  output logic            misaligned_wb
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  logic [1:0]      off;
  logic            mis_al, bad_ld, bad_st;
  logic [3:0]      be, we;
  logic [XLEN-1:0] wdata, rdata, lane, ld_val;
  wb_t             wb_d, wb_q;
  assign PCSrc = Branch_MEM_out && ((func3_out == F3_BEQ && zero_out) || (func3_out == F3_BNE && !zero_out));
  assign branch_target = pc_out;
  data_mem #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk), .we_i(we), .addr_i(ALU_out[ADDR_W+1:2]), .wdata_i(wdata), .rdata_o(rdata)
  );
  // Undefined funct3 is folded into the same trap path as a misaligned access.
  always_comb begin
    off = ALU_out[1:0];
    mis_al = (func3_out[1:0] == 2'b01 && off[0]) || (func3_out[1:0] == 2'b10 && off != 2'b00);
    bad_ld = MemRead_MEM_out && (!is_load(func3_out) || mis_al);
    bad_st = MemWrite_MEM_out && (!is_store(func3_out) || mis_al);
    be = func3_out == F3_SB ? 4'b0001 << off : func3_out == F3_SH ? 4'b0011 << off : 4'b1111;
    we = (MemWrite_MEM_out && !bad_st && !reset) ? be : 4'b0000;
    wdata = func3_out == F3_SB ? {4{reg2_data_out[7:0]}} :
            func3_out == F3_SH ? {2{reg2_data_out[15:0]}} : reg2_data_out;
    lane = rdata >> {off, 3'b000};
    ld_val = func3_out == F3_LB  ? {{24{lane[7]}}, lane[7:0]} :
             func3_out == F3_LH  ? {{16{lane[15]}}, lane[15:0]} :
             func3_out == F3_LBU ? {24'b0, lane[7:0]} :
             func3_out == F3_LHU ? {16'b0, lane[15:0]} : rdata;
    wb_d.mem_data = (MemRead_MEM_out && !bad_ld && !bad_st) ? ld_val : '0;
    wb_d.alu = ALU_out;
    wb_d.rd = rd_out;
    wb_d.mtr = MemtoReg_WB_out;
    wb_d.rw = RegWrite_WB_out && !bad_ld;
    wb_d.mis = bad_ld || bad_st;
  end
  always_ff @(posedge clk) wb_q <= reset ? '0 : wb_d;
  assign mem_data_wb = wb_q.mem_data;
  assign alu_wb = wb_q.alu;
  assign rd_wb = wb_q.rd;
  assign MemtoReg_wb = wb_q.mtr;
  assign RegWrite_wb = wb_q.rw;
  assign misaligned_wb = wb_q.mis;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: byte-array reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_stage;
  localparam int DEPTH = 256;
  localparam int NB = DEPTH * 4;
  logic clk = 0;
  logic reset = 1, zero_out = 0, MemtoReg_WB_out = 0, RegWrite_WB_out = 0;
  logic MemRead_MEM_out = 0, MemWrite_MEM_out = 0, Branch_MEM_out = 0;
  logic [31:0] ALU_out = 0, pc_out = 0, reg2_data_out = 0;
  logic [4:0] rd_out = 0;
  logic [2:0] func3_out = 0;
  logic PCSrc, MemtoReg_wb, RegWrite_wb, misaligned_wb;
  logic [31:0] branch_target, mem_data_wb, alu_wb;
  logic [4:0] rd_wb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .zero_out(zero_out), .ALU_out(ALU_out), .pc_out(pc_out),
    .reg2_data_out(reg2_data_out), .rd_out(rd_out), .func3_out(func3_out),
    .MemtoReg_WB_out(MemtoReg_WB_out), .RegWrite_WB_out(RegWrite_WB_out),
    .MemRead_MEM_out(MemRead_MEM_out), .MemWrite_MEM_out(MemWrite_MEM_out),
    .Branch_MEM_out(Branch_MEM_out), .PCSrc(PCSrc), .branch_target(branch_target),
    .mem_data_wb(mem_data_wb), .alu_wb(alu_wb), .rd_wb(rd_wb), .MemtoReg_wb(MemtoReg_wb),
    .RegWrite_wb(RegWrite_wb), .misaligned_wb(misaligned_wb)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, results from access size and alignment arithmetic.
  logic [7:0] mm [NB];
  bit kn [NB];
  bit started = 0, e_ok = 1;
  logic [31:0] e_mem = 0, e_alu = 0, v;
  logic [4:0] e_rd = 0;
  bit e_mtr = 0, e_rw = 0, e_mis = 0;
  int a, s;
  bit al, bl, bs, known, rd_ok;
  always @(posedge clk) begin
    if (reset) begin
      e_mem = 0; e_alu = 0; e_rd = 0; e_mtr = 0; e_rw = 0; e_mis = 0; e_ok = 1;
    end else begin
      a = int'(ALU_out % NB);
      s = func3_out[1:0] == 0 ? 1 : func3_out[1:0] == 1 ? 2 : 4;
      al = (a % s) == 0;
      bl = MemRead_MEM_out && !(func3_out inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} && al);
      bs = MemWrite_MEM_out && !(func3_out inside {3'd0, 3'd1, 3'd2} && al);
      rd_ok = MemRead_MEM_out && !bl && !bs;
      v = 0; known = 1;
      if (rd_ok) begin
        for (int i = 0; i < s; i++) begin
          v = v | (32'(mm[a+i]) << (8 * i));
          known = known && kn[a+i];
        end
        if (!func3_out[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8 * s));
      end
      e_mem = rd_ok ? v : 0;
      e_ok = !rd_ok || known;
      if (MemWrite_MEM_out && !bs)
        for (int i = 0; i < s; i++) begin
          mm[a+i] = 8'(reg2_data_out >> (8 * i));
          kn[a+i] = 1;
        end
      e_alu = ALU_out; e_rd = rd_out; e_mtr = MemtoReg_WB_out;
      e_rw = RegWrite_WB_out && !bl; e_mis = bl || bs;
    end
    started = 1;
  end

  always @(negedge clk) if (started) begin
    if (e_ok) chk("mem_data_wb", mem_data_wb, e_mem);
    chk("alu_wb", alu_wb, e_alu);
    chk("rd_wb", 32'(rd_wb), 32'(e_rd));
    chk("MemtoReg_wb", 32'(MemtoReg_wb), 32'(e_mtr));
    chk("RegWrite_wb", 32'(RegWrite_wb), 32'(e_rw));
    chk("misaligned_wb", 32'(misaligned_wb), 32'(e_mis));
    chk("PCSrc", 32'(PCSrc), 32'(Branch_MEM_out && ((func3_out == 0 && zero_out) || (func3_out == 1 && !zero_out))));
    chk("branch_target", branch_target, pc_out);
  end

  task automatic mop(input bit rst, input bit mr, input bit mw, input logic [2:0] f3,
                     input logic [31:0] ad, input logic [31:0] wd, input bit rw);
    reset = rst; MemRead_MEM_out = mr; MemWrite_MEM_out = mw; func3_out = f3;
    ALU_out = ad; reg2_data_out = wd; RegWrite_WB_out = rw; MemtoReg_WB_out = mr;
    rd_out = 5'(ad >> 2); Branch_MEM_out = 0; zero_out = 0;
    @(posedge clk); #2;
  endtask

  task automatic brt(input bit b, input logic [2:0] f3, input bit z, input logic [31:0] pc, input bit exp);
    MemRead_MEM_out = 0; MemWrite_MEM_out = 0; Branch_MEM_out = b; func3_out = f3;
    zero_out = z; pc_out = pc; #1;
    chk("lit_pcsrc", 32'(PCSrc), 32'(exp));
    chk("lit_target", branch_target, pc);
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (2) @(posedge clk); #2;
    chk("lit_reset_mem", mem_data_wb, 0);
    chk("lit_reset_rw", 32'({rd_wb, MemtoReg_wb, RegWrite_wb, misaligned_wb}), 0);
    chk("lit_reset_alu", alu_wb, 0);
    mop(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    mop(0, 1, 0, 3'b010, 32'h10, 0, 1);
    chk("lit_lw", mem_data_wb, 32'hDEADBEEF);
    chk("lit_lw_rd", 32'(rd_wb), 4);
    chk("lit_lw_rw", 32'(RegWrite_wb), 1);
    mop(0, 0, 1, 3'b000, 32'h13, 32'h12345680, 0);
    mop(0, 1, 0, 3'b000, 32'h13, 0, 1);
    chk("lit_lb", mem_data_wb, 32'hFFFFFF80);
    mop(0, 1, 0, 3'b100, 32'h13, 0, 1);
    chk("lit_lbu", mem_data_wb, 32'h00000080);
    mop(0, 1, 0, 3'b010, 32'h10, 0, 1);
    chk("lit_sb_others", mem_data_wb, 32'h80ADBEEF);
    mop(0, 0, 1, 3'b001, 32'h11, 32'hAAAA, 0);
    chk("lit_sh_mis", 32'(misaligned_wb), 1);
    mop(0, 1, 0, 3'b001, 32'h11, 0, 1);
    chk("lit_lh_mis", 32'(misaligned_wb), 1);
    chk("lit_lh_mis_rw", 32'(RegWrite_wb), 0);
    chk("lit_lh_mis_data", mem_data_wb, 0);
    mop(0, 1, 0, 3'b010, 32'h10, 0, 1);
    chk("lit_sh_nowrite", mem_data_wb, 32'h80ADBEEF);
    chk("lit_mis_clear", 32'(misaligned_wb), 0);
    brt(1, 3'b000, 1, 32'h40, 1);
    brt(1, 3'b001, 1, 32'h40, 0);
    brt(1, 3'b001, 0, 32'h44, 1);
    brt(1, 3'b010, 1, 32'h48, 0);
    reset = 1;
    brt(0, 3'b000, 1, 32'h4C, 0);
    mop(0, 1, 0, 3'b010, 32'h10, 0, 1);
    mop(1, 0, 1, 3'b010, 32'h10, 32'h11111111, 1);
    chk("lit_rst_wb", 32'({rd_wb, MemtoReg_wb, RegWrite_wb, misaligned_wb}), 0);
    chk("lit_rst_alu", alu_wb, 0);
    mop(0, 1, 0, 3'b010, 32'h10, 0, 1);
    chk("lit_rst_store_dropped", mem_data_wb, 32'h80ADBEEF);
    mop(0, 0, 1, 3'b010, 32'(NB + 8), 32'hCAFEF00D, 0);
    mop(0, 1, 0, 3'b010, 32'h8, 0, 1);
    chk("lit_wrap", mem_data_wb, 32'hCAFEF00D);
    mop(0, 0, 1, 3'b001, 32'h22, 32'h1234BEEF, 0);
    mop(0, 1, 0, 3'b001, 32'h22, 0, 1);
    chk("lit_lh", mem_data_wb, 32'hFFFFBEEF);
    mop(0, 1, 0, 3'b101, 32'h22, 0, 1);
    chk("lit_lhu", mem_data_wb, 32'h0000BEEF);
    mop(0, 1, 0, 3'b011, 32'h8, 0, 1);
    chk("lit_undef_f3", 32'({misaligned_wb, RegWrite_wb}), 32'b10);
    mop(0, 1, 1, 3'b010, 32'h8, 32'h01020304, 1);
    chk("lit_rmw_old", mem_data_wb, 32'hCAFEF00D);
    mop(0, 1, 0, 3'b010, 32'h8, 0, 1);
    chk("lit_rmw_new", mem_data_wb, 32'h01020304);
    mop(0, 0, 0, 3'b010, 32'h8, 0, 1);
    chk("lit_noread", mem_data_wb, 0);
    mop(0, 0, 1, 3'b000, 32'h9, 32'h77, 0);
    mop(0, 1, 0, 3'b010, 32'h8, 0, 1);
    chk("lit_sb_lane1", mem_data_wb, 32'h01027704);
    mop(0, 0, 1, 3'b001, 32'hA, 32'h5566, 0);
    mop(0, 1, 0, 3'b010, 32'h8, 0, 1);
    chk("lit_sh_upper", mem_data_wb, 32'h55667704);
    mop(0, 0, 0, 3'b000, 0, 0, 0);
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
